// File: rtl/riscv_ctrl_seq_pkg.sv
// Shared definitions for the multi-cycle control sequencer:
// RV32I major opcodes, sequencer state encodings, trap-cause codes and
// small opcode classification helpers used by the sequencer.
package riscv_ctrl_seq_pkg;

    localparam int unsigned OPC_W   = 7;
    localparam int unsigned CAUSE_W = 2;

    // RV32I major opcodes (inst[6:0])
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_SYS    = 7'b1110011;

    // Sequencer states
    typedef enum logic [2:0] {
        CTRL_IDLE     = 3'd0,
        CTRL_FETCH    = 3'd1,
        CTRL_DECODE   = 3'd2,
        CTRL_EXEC     = 3'd3,
        CTRL_MEM_REQ  = 3'd4,
        CTRL_MEM_WAIT = 3'd5,
        CTRL_WB       = 3'd6,
        CTRL_TRAP     = 3'd7
    } ctrlState_t;

    // Trap causes
    localparam logic [CAUSE_W-1:0] TRAP_ILLEGAL = 2'd0;
    localparam logic [CAUSE_W-1:0] TRAP_IF_TO   = 2'd1;
    localparam logic [CAUSE_W-1:0] TRAP_MEM_TO  = 2'd2;

    // True for every opcode the core implements
    function automatic logic isLegalOpc(input logic [OPC_W-1:0] opc);
        logic legal;
        legal = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYS: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    // True when the instruction class produces a result for rd
    // (SYS with funct3 == 0 is ECALL/EBREAK/xRET and writes nothing)
    function automatic logic writesRd(input logic [OPC_W-1:0] opc, input logic [2:0] funct3);
        logic wr;
        wr = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OP_IMM, OPC_OP: wr = 1'b1;
            OPC_SYS:                      wr = (funct3 != 3'd0);
            default:                      wr = 1'b0;
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/riscv_ctrl_seq_wdt.sv
// Handshake wait counter. Counts waiting cycles; expire flags the last
// allowed waiting cycle (count == TIMEOUT-1).
// Ports: clk, rst (sync, active-high), clr (zero the count), inc (count one
// waiting cycle), expire (combinational compare of the current count).
module riscv_ctrl_seq_wdt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/riscv_ctrl_seq.sv
// Multi-cycle instruction sequencer: holds the instruction register and steps
// each instruction through FETCH, DECODE, EXEC, optional MEM_REQ/MEM_WAIT and
// WB, trapping on illegal opcodes or IFU/LSU handshake time-outs.
// Ports: clk, rst (sync, active-high), run; IFU fetch handshake (if_req,
// if_rsp_valid, if_rsp_inst); inst to ID decoders; ex_en; LSU handshake
// (lsu_req_valid, lsu_req_ready, lsu_we, lsu_rsp_valid); rf_we, pc_we;
// trap, trap_cause; busy. All outputs are registered.
module riscv_ctrl_seq
    import riscv_ctrl_seq_pkg::*;
#(
    parameter int unsigned           INST_WIDTH = 32,
    parameter int unsigned           TIMEOUT    = 255,
    parameter logic [INST_WIDTH-1:0] RESET_INST = INST_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    output logic                  if_req,
    input  logic                  if_rsp_valid,
    input  logic [INST_WIDTH-1:0] if_rsp_inst,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  ex_en,
    output logic                  lsu_req_valid,
    input  logic                  lsu_req_ready,
    output logic                  lsu_we,
    input  logic                  lsu_rsp_valid,
    output logic                  rf_we,
    output logic                  pc_we,
    output logic                  trap,
    output logic [CAUSE_W-1:0]    trap_cause,
    output logic                  busy
);

    ctrlState_t       state;
    logic             waiting;
    logic             done;
    logic             wdtInc;
    logic             wdtExpire;
    logic [OPC_W-1:0] opcode;
    logic             isMem;
    logic             rfWrite;

    assign opcode  = inst[OPC_W-1:0];
    assign isMem   = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    assign rfWrite = writesRd(opcode, inst[14:12]) && (inst[11:7] != 5'd0);

    // Which handshake is being waited on, and whether it completes this cycle
    always_comb begin
        waiting = 1'b0;
        done    = 1'b0;
        case (state)
            CTRL_FETCH: begin
                waiting = 1'b1;
                done    = if_rsp_valid;
            end
            CTRL_MEM_REQ: begin
                waiting = 1'b1;
                done    = lsu_req_ready;
            end
            CTRL_MEM_WAIT: begin
                waiting = 1'b1;
                done    = lsu_rsp_valid;
            end
            default: begin
                waiting = 1'b0;
                done    = 1'b0;
            end
        endcase
    end

    // Any cycle that is not an unfinished wait restarts the count, so every
    // wait state is entered with a zero count
    assign wdtInc = waiting && !done;

    riscv_ctrl_seq_wdt #(
        .TIMEOUT (TIMEOUT)
    ) uWdt (
        .clk    (clk),
        .rst    (rst),
        .clr    (!wdtInc),
        .inc    (wdtInc),
        .expire (wdtExpire)
    );

    // State register; each output is registered as the value belonging to
    // the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= CTRL_IDLE;
            inst          <= RESET_INST;
            if_req        <= 1'b0;
            ex_en         <= 1'b0;
            lsu_req_valid <= 1'b0;
            lsu_we        <= 1'b0;
            rf_we         <= 1'b0;
            pc_we         <= 1'b0;
            trap          <= 1'b0;
            trap_cause    <= TRAP_ILLEGAL;
            busy          <= 1'b0;
        end else begin
            if_req        <= 1'b0;
            ex_en         <= 1'b0;
            lsu_req_valid <= 1'b0;
            lsu_we        <= 1'b0;
            rf_we         <= 1'b0;
            pc_we         <= 1'b0;
            trap          <= 1'b0;
            busy          <= 1'b1;
            case (state)
                CTRL_IDLE: begin
                    if (run) begin
                        state  <= CTRL_FETCH;
                        if_req <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                CTRL_FETCH: begin
                    if (if_rsp_valid) begin
                        state <= CTRL_DECODE;
                        inst  <= if_rsp_inst;
                    end else if (wdtExpire) begin
                        state      <= CTRL_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= TRAP_IF_TO;
                    end else begin
                        if_req <= 1'b1;
                    end
                end
                CTRL_DECODE: begin
                    if (isLegalOpc(opcode)) begin
                        state <= CTRL_EXEC;
                        ex_en <= 1'b1;
                    end else begin
                        state      <= CTRL_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= TRAP_ILLEGAL;
                    end
                end
                CTRL_EXEC: begin
                    if (isMem) begin
                        state         <= CTRL_MEM_REQ;
                        lsu_req_valid <= 1'b1;
                        lsu_we        <= (opcode == OPC_STORE);
                    end else begin
                        state <= CTRL_WB;
                        pc_we <= 1'b1;
                        rf_we <= rfWrite;
                    end
                end
                CTRL_MEM_REQ: begin
                    if (lsu_req_ready) begin
                        state <= CTRL_MEM_WAIT;
                    end else if (wdtExpire) begin
                        state      <= CTRL_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= TRAP_MEM_TO;
                    end else begin
                        lsu_req_valid <= 1'b1;
                        lsu_we        <= (opcode == OPC_STORE);
                    end
                end
                CTRL_MEM_WAIT: begin
                    if (lsu_rsp_valid) begin
                        state <= CTRL_WB;
                        pc_we <= 1'b1;
                        rf_we <= rfWrite;
                    end else if (wdtExpire) begin
                        state      <= CTRL_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= TRAP_MEM_TO;
                    end
                end
                CTRL_WB: begin
                    if (run) begin
                        state  <= CTRL_FETCH;
                        if_req <= 1'b1;
                    end else begin
                        state <= CTRL_IDLE;
                        busy  <= 1'b0;
                    end
                end
                CTRL_TRAP: begin
                    state <= CTRL_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= CTRL_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_ctrl_seq.sv
// Bench for riscv_ctrl_seq. Each instruction is walked through a procedural
// model of its life (fetch wait, decode, exec, memory waits, write-back or
// trap); every cycle the expected outputs of that step are compared with the
// DUT, then the step's inputs are driven.
module tb_riscv_ctrl_seq;

    localparam int unsigned TO  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        if_req;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_inst;
    logic [31:0] inst;
    logic        ex_en;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_we;
    logic        lsu_rsp_valid;
    logic        rf_we;
    logic        pc_we;
    logic        trap;
    logic [1:0]  trap_cause;
    logic        busy;

    riscv_ctrl_seq #(
        .INST_WIDTH (32),
        .TIMEOUT    (TO),
        .RESET_INST (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .if_req        (if_req),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_inst   (if_rsp_inst),
        .inst          (inst),
        .ex_en         (ex_en),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_we        (lsu_we),
        .lsu_rsp_valid (lsu_rsp_valid),
        .rf_we         (rf_we),
        .pc_we         (pc_we),
        .trap          (trap),
        .trap_cause    (trap_cause),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int unsigned nChecks = 0;
    int unsigned nErrors = 0;

    // Model expectations for the current cycle
    logic        expIfReq, expExEn, expLsuV, expLsuWe, expRfWe, expPcWe, expTrap, expBusy;
    logic [1:0]  modelCause;
    logic [31:0] modelInst;
    logic        atFetch;

    logic [6:0] legalOpc [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                  7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                  7'b0110011, 7'b0001111, 7'b1110011};

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        if (obs !== expv) begin
            nErrors++;
            $display("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, expv);
        end
    endtask

    function automatic logic noise();
        return ($urandom_range(0, 3) == 0);
    endfunction

    function automatic logic isLegal(input logic [6:0] opc);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 11; i++) if (legalOpc[i] == opc) hit = 1'b1;
        return hit;
    endfunction

    // rd is written for result-producing classes and CSR ops, never to x0
    function automatic logic expectRfWrite(input logic [31:0] ins);
        logic [6:0] opc;
        logic       cls;
        opc = ins[6:0];
        cls = (opc == 7'b0110111) || (opc == 7'b0010111) || (opc == 7'b1101111) ||
              (opc == 7'b1100111) || (opc == 7'b0000011) || (opc == 7'b0010011) ||
              (opc == 7'b0110011) || ((opc == 7'b1110011) && (ins[14:12] != 3'd0));
        return cls && (ins[11:7] != 5'd0);
    endfunction

    task automatic setExp(input logic ifr, input logic ex, input logic lv, input logic lw,
                          input logic rw, input logic pw, input logic tr, input logic bz);
        expIfReq = ifr; expExEn = ex; expLsuV = lv; expLsuWe = lw;
        expRfWe  = rw;  expPcWe = pw; expTrap = tr; expBusy  = bz;
    endtask

    // Compare this cycle's outputs, then drive this cycle's inputs
    task automatic step(input logic rstIn, input logic runIn, input logic ifV,
                        input logic [31:0] ifI, input logic rdy, input logic rspV);
        @(negedge clk);
        checkVal("if_req",        32'(if_req),        32'(expIfReq));
        checkVal("ex_en",         32'(ex_en),         32'(expExEn));
        checkVal("lsu_req_valid", 32'(lsu_req_valid), 32'(expLsuV));
        if (expLsuV) checkVal("lsu_we", 32'(lsu_we), 32'(expLsuWe));
        checkVal("rf_we",         32'(rf_we),         32'(expRfWe));
        checkVal("pc_we",         32'(pc_we),         32'(expPcWe));
        checkVal("trap",          32'(trap),          32'(expTrap));
        checkVal("trap_cause",    32'(trap_cause),    32'(modelCause));
        checkVal("busy",          32'(busy),          32'(expBusy));
        checkVal("inst",          inst,               modelInst);
        rst           = rstIn;
        run           = runIn;
        if_rsp_valid  = ifV;
        if_rsp_inst   = ifI;
        lsu_req_ready = rdy;
        lsu_rsp_valid = rspV;
        @(posedge clk);
    endtask

    task automatic idleStep(input logic runIn);
        setExp(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, runIn, noise(), $urandom, noise(), noise());
    endtask

    task automatic trapStep(input logic [1:0] cause);
        modelCause = cause;
        setExp(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, noise(), noise(), $urandom, noise(), noise());
    endtask

    // One instruction, starting in its first fetch cycle. A latency equal to
    // TO means the handshake never completes inside the time-out window.
    task automatic runInst(input logic [31:0] instr, input int ifLat, input int rdyLat,
                           input int rspLat, input logic runAfter, input logic abortWait,
                           output logic toFetch);
        logic hit;
        logic isStore;
        toFetch = 1'b0;
        hit     = 1'b0;
        for (int c = 0; c < TO; c++) begin
            setExp(1, 0, 0, 0, 0, 0, 0, 1);
            hit = (c == ifLat);
            step(0, noise(), hit, hit ? instr : $urandom, noise(), noise());
            if (hit) break;
        end
        if (!hit) begin
            trapStep(2'd1);
            return;
        end
        modelInst = instr;
        setExp(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, noise(), noise(), $urandom, noise(), noise());
        if (!isLegal(instr[6:0])) begin
            trapStep(2'd0);
            return;
        end
        setExp(0, 1, 0, 0, 0, 0, 0, 1);
        step(0, noise(), noise(), $urandom, noise(), noise());
        if ((instr[6:0] == 7'b0000011) || (instr[6:0] == 7'b0100011)) begin
            isStore = (instr[6:0] == 7'b0100011);
            hit     = 1'b0;
            for (int c = 0; c < TO; c++) begin
                setExp(0, 0, 1, isStore, 0, 0, 0, 1);
                hit = (c == rdyLat);
                step(0, noise(), noise(), $urandom, hit, noise());
                if (hit) break;
            end
            if (!hit) begin
                trapStep(2'd2);
                return;
            end
            for (int c = 0; c < TO; c++) begin
                setExp(0, 0, 0, 0, 0, 0, 0, 1);
                if (abortWait) begin
                    step(1, 0, 0, $urandom, 0, 0);
                    modelInst  = NOP;
                    modelCause = 2'd0;
                    return;
                end
                hit = (c == rspLat);
                step(0, noise(), noise(), $urandom, noise(), hit);
                if (hit) break;
            end
            if (!hit) begin
                trapStep(2'd2);
                return;
            end
        end
        setExp(0, 0, 0, 0, expectRfWrite(instr), 1, 0, 1);
        step(0, runAfter, noise(), $urandom, noise(), noise());
        toFetch = runAfter;
    endtask

    task automatic doInst(input logic [31:0] instr, input int ifLat, input int rdyLat,
                          input int rspLat, input logic runAfter, input logic abortWait);
        logic nxt;
        if (!atFetch) idleStep(1'b1);
        runInst(instr, ifLat, rdyLat, rspLat, runAfter, abortWait, nxt);
        atFetch = nxt;
    endtask

    function automatic logic [31:0] randInst();
        logic [31:0] r;
        logic [6:0]  opc;
        int          k;
        r = $urandom;
        k = int'($urandom_range(0, 12));
        if (k < 11) begin
            opc = legalOpc[k];
        end else begin
            opc = 7'($urandom);
            while (isLegal(opc)) opc = 7'($urandom);
        end
        if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
        return {r[31:7], opc};
    endfunction

    initial begin
        rst = 1'b1; run = 1'b0; if_rsp_valid = 1'b0; if_rsp_inst = '0;
        lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
        modelInst = NOP; modelCause = 2'd0; atFetch = 1'b0;
        @(posedge clk);
        @(posedge clk);

        doInst(32'h0010_0093, 0, 0, 0, 1, 0);   // ADDI x1, minimum latency
        doInst(32'h0000_2103, 0, 2, 2, 1, 0);   // LW x2, delayed ready and response
        doInst(32'h0020_2023, 1, 2, 2, 1, 0);   // SW, no rd write
        doInst(32'h0000_0013, 0, 0, 0, 1, 0);   // ADDI x0
        doInst(32'h0000_0463, 0, 0, 0, 0, 0);   // BEQ with rd-field bits set
        doInst(32'h0000_0000, 0, 0, 0, 1, 0);   // illegal opcode
        doInst(32'h0010_0093, TO, 0, 0, 1, 0);  // fetch time-out
        doInst(32'h0010_0093, TO - 1, 0, 0, 0, 0); // response on last allowed cycle
        doInst(32'h3400_12f3, 0, 0, 0, 1, 0);   // CSRRW x5 writes rd
        doInst(32'h0000_0073, 0, 0, 0, 1, 0);   // ECALL writes nothing
        doInst(32'h0000_2103, 0, TO, 0, 1, 0);  // memory request time-out
        doInst(32'h0000_2103, 0, 0, TO, 1, 0);  // memory response time-out
        doInst(32'h0000_2103, 0, TO - 1, TO - 1, 1, 0);
        doInst(32'h0000_2103, 0, 1, 0, 1, 1);   // reset during MEM_WAIT
        idleStep(1'b0);                         // reset values observed here

        for (int n = 0; n < 400; n++) begin
            if (!atFetch) begin
                int gap;
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) idleStep(1'b0);
            end
            doInst(randInst(), int'($urandom_range(0, TO)), int'($urandom_range(0, TO)),
                   int'($urandom_range(0, TO)), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 40) == 0));
        end
        if (!atFetch) idleStep(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
